// File: rtl/ddr4_traffic_gen.sv
// DDR4 traffic generator/checker: runs NUM_TXN ACT -> WR burst -> RD burst -> PRE
// transactions across an incrementing address, writing LFSR pattern data and
// counting read-back beats that differ from the regenerated pattern.
module ddr4_traffic_gen #(
    parameter int          ADDRWIDTH     = 17,
    parameter int          RANKS         = 1,
    parameter int          BANKGROUPS    = 4,
    parameter int          BANKSPERGROUP = 4,
    parameter int          COLS          = 1024,
    parameter int          DQWIDTH       = 72,
    parameter int          DQSWIDTH      = 18,
    parameter int          BL            = 8,
    parameter int          TRCD          = 15,
    parameter int          TCL           = 15,
    parameter int          TRP           = 15,
    parameter int          TWTR          = 4,
    parameter int          NUM_TXN       = 16,
    parameter logic [31:0] SEED          = 32'hACE1_0001,
    localparam int         BAW           = (BANKSPERGROUP > 1) ? $clog2(BANKSPERGROUP) : 1,
    localparam int         BGW           = (BANKGROUPS > 1) ? $clog2(BANKGROUPS) : 1
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BAW-1:0]       ba,
    output logic [BGW-1:0]       bg,
    output logic [DQWIDTH-1:0]   dq_out,
    output logic [DQSWIDTH-1:0]  dqs_t_out,
    output logic [DQSWIDTH-1:0]  dqs_c_out,
    output logic                 dq_oe,
    input  logic [DQWIDTH-1:0]   dq_in,
    output logic [15:0]          err_count,
    output logic [15:0]          txn_count
);

    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RKW  = (RANKS > 1) ? $clog2(RANKS) : 1;
    localparam int NREP = (DQWIDTH - 8) / 64;
    localparam int PW   = NREP * 64;
    localparam logic [31:0]          POLY = 32'h8020_0003;
    localparam logic [ADDRWIDTH-1:0] NOP  = {3'b111, {(ADDRWIDTH-3){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, ACT, TRCD_W, WR, TWTR_W, RD, TCL_W, RBURST, PRE, TRP_W, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [COLW-1:0]     col_q;
    logic [BAW-1:0]      ba_q, ba_hold_q;
    logic [BGW-1:0]      bg_q, bg_hold_q;
    logic [RKW-1:0]      rank_q;
    logic [ADDRWIDTH-1:0] row_q;
    logic [31:0]         wr_lfsr_q, rd_lfsr_q;
    logic [15:0]         err_q, txn_q;
    logic                cmd;
    logic                unused_ecc;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [PW-1:0] pattern(input logic [31:0] v);
        return {NREP{v, ~v}};
    endfunction

    function automatic logic [ADDRWIDTH-1:0] cmd_word(input logic [2:0] code,
                                                      input logic [COLW-1:0] col);
        return {code, (ADDRWIDTH-3)'(col)};
    endfunction

    assign unused_ecc = ^dq_in[DQWIDTH-1 -: 8];
    assign err_count  = err_q;
    assign txn_count  = txn_q;

    // State, wait counter and held bank/bank-group registers
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ba_hold_q <= '0;
            bg_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ba_hold_q <= ba;
            bg_hold_q <= bg;
        end
    end

    // Next-state/wait-length selection and command/data bus decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 16'd1;
        cmd       = 1'b0;
        cs_n      = '1;
        act_n     = 1'b1;
        A         = NOP;
        dq_oe     = 1'b0;
        dq_out    = '0;
        dqs_t_out = '0;
        dqs_c_out = '0;
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
        case (state_q)
            IDLE: if (start) state_d = ACT;
            ACT: begin
                cmd   = 1'b1;
                act_n = 1'b0;
                A     = row_q;
                if (TRCD > 1) begin
                    state_d = TRCD_W;
                    cnt_d   = 16'(TRCD - 2);
                end else begin
                    state_d = WR;
                    cnt_d   = 16'(BL - 1);
                end
            end
            TRCD_W: if (cnt_q == '0) begin
                state_d = WR;
                cnt_d   = 16'(BL - 1);
            end
            WR: begin
                // Command only in the first beat; counter was loaded with BL-1 on entry
                if (cnt_q == 16'(BL - 1)) begin
                    cmd = 1'b1;
                    A   = cmd_word(3'b100, col_q);
                end
                dq_oe     = 1'b1;
                dq_out    = {8'h00, pattern(wr_lfsr_q)};
                dqs_t_out = '1;
                if (cnt_q == '0) begin
                    state_d = TWTR_W;
                    cnt_d   = 16'(TWTR - 1);
                end
            end
            TWTR_W: if (cnt_q == '0) state_d = RD;
            RD: begin
                cmd = 1'b1;
                A   = cmd_word(3'b101, col_q);
                if (TCL > 1) begin
                    state_d = TCL_W;
                    cnt_d   = 16'(TCL - 2);
                end else begin
                    state_d = RBURST;
                    cnt_d   = 16'(BL - 1);
                end
            end
            TCL_W: if (cnt_q == '0) begin
                state_d = RBURST;
                cnt_d   = 16'(BL - 1);
            end
            RBURST: if (cnt_q == '0) state_d = PRE;
            PRE: begin
                cmd = 1'b1;
                A   = cmd_word(3'b010, '0);
                if (TRP > 1) begin
                    state_d = TRP_W;
                    cnt_d   = 16'(TRP - 2);
                end else begin
                    // txn_count is bumped this cycle, so compare against the pre-bump value
                    state_d = (txn_q == 16'(NUM_TXN - 1)) ? DONE : ACT;
                end
            end
            TRP_W: if (cnt_q == '0) state_d = (txn_q == 16'(NUM_TXN)) ? DONE : ACT;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cmd) cs_n = ~(RANKS'(1) << rank_q);
        ba = cmd ? ba_q : ba_hold_q;
        bg = cmd ? bg_q : bg_hold_q;
    end

    // Address stepping, pattern LFSRs and run counters
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            ba_q      <= '0;
            bg_q      <= '0;
            rank_q    <= '0;
            row_q     <= '0;
            wr_lfsr_q <= SEED;
            rd_lfsr_q <= SEED;
            err_q     <= '0;
            txn_q     <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                col_q     <= '0;
                ba_q      <= '0;
                bg_q      <= '0;
                rank_q    <= '0;
                row_q     <= '0;
                wr_lfsr_q <= SEED;
                rd_lfsr_q <= SEED;
                err_q     <= '0;
                txn_q     <= '0;
            end
        end else begin
            if (state_q == WR) wr_lfsr_q <= lfsr_step(wr_lfsr_q);
            if (state_q == RBURST) begin
                rd_lfsr_q <= lfsr_step(rd_lfsr_q);
                if (dq_in[PW-1:0] != pattern(rd_lfsr_q) && err_q != 16'hFFFF)
                    err_q <= err_q + 16'd1;
            end
            if (state_q == PRE) begin
                txn_q <= txn_q + 16'd1;
                if (32'(col_q) + 32'(BL) >= 32'(COLS)) begin
                    col_q <= '0;
                    if (ba_q == BAW'(BANKSPERGROUP - 1)) begin
                        ba_q <= '0;
                        if (bg_q == BGW'(BANKGROUPS - 1)) begin
                            bg_q <= '0;
                            if (rank_q == RKW'(RANKS - 1)) begin
                                rank_q <= '0;
                                row_q  <= row_q + ADDRWIDTH'(1);
                            end else begin
                                rank_q <= rank_q + RKW'(1);
                            end
                        end else begin
                            bg_q <= bg_q + BGW'(1);
                        end
                    end else begin
                        ba_q <= ba_q + BAW'(1);
                    end
                end else begin
                    col_q <= col_q + COLW'(BL);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr4_traffic_gen.sv
// Directed bench for ddr4_traffic_gen: four instances cover default timing with a
// loopback DIMM, column/bank stepping, rank/row stepping and error saturation.
module tb_ddr4_traffic_gen;

    logic ck_t = 1'b0;
    logic reset_n;
    always #5 ck_t = ~ck_t;

    // Instance A: defaults, one transaction, loopback read data
    logic        start_a, busy_a, done_a, act_n_a, dq_oe_a;
    logic [0:0]  cs_n_a;
    logic [16:0] A_a;
    logic [1:0]  ba_a, bg_a;
    logic [71:0] dq_out_a, dq_in_a;
    logic [17:0] dqs_t_a, dqs_c_a;
    logic [15:0] err_a, txn_a;

    // Instance B: COLS=16, five transactions
    logic        start_b, busy_b, done_b, act_n_b;
    logic [0:0]  cs_n_b;
    logic [16:0] A_b;
    logic [1:0]  ba_b, bg_b;
    logic [71:0] unused_dq_out_b, dq_in_b;
    logic [17:0] unused_dqs_t_b, unused_dqs_c_b;
    logic        unused_dq_oe_b;
    logic [15:0] err_b, txn_b;

    // Instance C: two ranks, single bank, COLS=16
    logic        start_c, unused_busy_c, done_c, act_n_c;
    logic [1:0]  cs_n_c;
    logic [16:0] A_c;
    logic [0:0]  unused_ba_c, unused_bg_c;
    logic [71:0] unused_dq_out_c, dq_in_c;
    logic [17:0] unused_dqs_t_c, unused_dqs_c_c;
    logic        unused_dq_oe_c;
    logic [15:0] unused_err_c, txn_c;

    // Instance D: defaults, 16 transactions, read data tied low
    logic        start_d, unused_busy_d, done_d, unused_act_n_d;
    logic [0:0]  unused_cs_n_d;
    logic [16:0] unused_A_d;
    logic [1:0]  unused_ba_d, unused_bg_d;
    logic [71:0] unused_dq_out_d, dq_in_d;
    logic [17:0] unused_dqs_t_d, unused_dqs_c_d;
    logic        unused_dq_oe_d;
    logic [15:0] err_d, txn_d;

    ddr4_traffic_gen #(.NUM_TXN(1)) u_a (
        .ck_t(ck_t), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
        .cs_n(cs_n_a), .act_n(act_n_a), .A(A_a), .ba(ba_a), .bg(bg_a),
        .dq_out(dq_out_a), .dqs_t_out(dqs_t_a), .dqs_c_out(dqs_c_a), .dq_oe(dq_oe_a),
        .dq_in(dq_in_a), .err_count(err_a), .txn_count(txn_a));

    ddr4_traffic_gen #(.COLS(16), .NUM_TXN(5)) u_b (
        .ck_t(ck_t), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
        .cs_n(cs_n_b), .act_n(act_n_b), .A(A_b), .ba(ba_b), .bg(bg_b),
        .dq_out(unused_dq_out_b), .dqs_t_out(unused_dqs_t_b), .dqs_c_out(unused_dqs_c_b),
        .dq_oe(unused_dq_oe_b), .dq_in(dq_in_b), .err_count(err_b), .txn_count(txn_b));

    ddr4_traffic_gen #(.COLS(16), .BANKSPERGROUP(1), .BANKGROUPS(1), .RANKS(2), .NUM_TXN(5)) u_c (
        .ck_t(ck_t), .reset_n(reset_n), .start(start_c), .busy(unused_busy_c), .done(done_c),
        .cs_n(cs_n_c), .act_n(act_n_c), .A(A_c), .ba(unused_ba_c), .bg(unused_bg_c),
        .dq_out(unused_dq_out_c), .dqs_t_out(unused_dqs_t_c), .dqs_c_out(unused_dqs_c_c),
        .dq_oe(unused_dq_oe_c), .dq_in(dq_in_c), .err_count(unused_err_c), .txn_count(txn_c));

    ddr4_traffic_gen #(.NUM_TXN(16)) u_d (
        .ck_t(ck_t), .reset_n(reset_n), .start(start_d), .busy(unused_busy_d), .done(done_d),
        .cs_n(unused_cs_n_d), .act_n(unused_act_n_d), .A(unused_A_d), .ba(unused_ba_d),
        .bg(unused_bg_d), .dq_out(unused_dq_out_d), .dqs_t_out(unused_dqs_t_d),
        .dqs_c_out(unused_dqs_c_d), .dq_oe(unused_dq_oe_d), .dq_in(dq_in_d),
        .err_count(err_d), .txn_count(txn_d));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Loopback DIMM for instance A: stores written beats, replays them TCL after RD
    logic [71:0] wq[$];
    int          nc        = 0;
    int          rd_at     = -1000;
    int          flip_left = 0;
    logic [71:0] flip_mask = '0;
    bit          lb_zero   = 1'b0;

    initial begin : loopback
        logic [71:0] beat;
        dq_in_a = '0;
        forever begin
            @(negedge ck_t);
            nc++;
            if (dq_oe_a) wq.push_back(dq_out_a);
            if (!cs_n_a[0] && act_n_a && A_a[16:14] == 3'b101) rd_at = nc + 15;
            if (!lb_zero && nc >= rd_at && nc < rd_at + 8 && wq.size() != 0) begin
                beat = wq.pop_front();
                if (flip_left > 0) begin
                    beat = beat ^ flip_mask;
                    flip_left--;
                end
                dq_in_a = beat;
            end else begin
                dq_in_a = '0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          exp_col [5] = '{0, 8, 0, 8, 0};
    int          exp_ba  [5] = '{0, 0, 1, 1, 2};
    logic [1:0]  exp_cs  [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    logic [16:0] exp_row [5] = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd1};

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck_t);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            2:       return done_c;
            default: return done_d;
        endcase
    endfunction

    // start high for exactly one cycle (cycle 0); returns in cycle 1
    task automatic kick(input int w);
        case (w)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            2:       start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        cyc = 0;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
    endtask

    task automatic wait_done(input int w, input int limit);
        int t0;
        t0 = cyc;
        while (!done_of(w) && cyc - t0 < limit) step();
        check("done_seen", 72'(done_of(w)), 72'(1'b1));
    endtask

    initial begin : stim
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        dq_in_b = '0;
        dq_in_c = '0;
        dq_in_d = '0;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst_busy",  72'(busy_a),  72'(1'b0));
        check("rst_done",  72'(done_a),  72'(1'b0));
        check("rst_cs_n",  72'(cs_n_a),  72'(1'b1));
        check("rst_act_n", 72'(act_n_a), 72'(1'b1));
        check("rst_A",     72'(A_a),     72'(17'h1C000));
        check("rst_ba_bg", 72'({ba_a, bg_a}), 72'(4'h0));
        check("rst_dq_oe", 72'(dq_oe_a), 72'(1'b0));
        check("rst_dq",    dq_out_a,     72'h0);
        check("rst_dqs",   72'({dqs_t_a, dqs_c_a}), 72'(36'h0));
        check("rst_cnts",  72'({err_a, txn_a}), 72'(32'h0));

        // First run: ACT, WR command and opening beats, then reset mid-burst
        kick(0);
        check("act_cs_n",  72'(cs_n_a),  72'(1'b0));
        check("act_act_n", 72'(act_n_a), 72'(1'b0));
        check("act_row",   72'(A_a),     72'(17'h0));
        check("act_ba_bg", 72'({ba_a, bg_a}), 72'(4'h0));
        check("act_busy",  72'(busy_a),  72'(1'b1));
        step_to(15);
        check("pre_wr_nop", 72'(A_a), 72'(17'h1C000));
        step_to(16);
        check("wr_cs_n",   72'(cs_n_a),  72'(1'b0));
        check("wr_act_n",  72'(act_n_a), 72'(1'b1));
        check("wr_A",      72'(A_a),     72'(17'h10000));
        check("wr_oe",     72'(dq_oe_a), 72'(1'b1));
        check("wr_beat0",  dq_out_a,     {8'h00, 32'hACE10001, 32'h531EFFFE});
        check("wr_dqs_t",  72'(dqs_t_a), 72'(18'h3FFFF));
        check("wr_dqs_c",  72'(dqs_c_a), 72'(18'h0));
        step();
        check("wr1_nop",   72'(A_a),     72'(17'h1C000));
        check("wr1_cs_n",  72'(cs_n_a),  72'(1'b1));
        check("wr_beat1",  dq_out_a,     {8'h00, 32'hD6508003, 32'h29AF7FFC});
        step();
        check("wr_beat2",  72'(dq_out_a[63:32]), 72'(32'hEB084002));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_oe",   72'(dq_oe_a), 72'(1'b0));
        check("arst_dq",   dq_out_a,     72'h0);
        check("arst_cs_n", 72'(cs_n_a),  72'(1'b1));
        check("arst_A",    72'(A_a),     72'(17'h1C000));
        check("arst_busy", 72'(busy_a),  72'(1'b0));
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_idle", 72'({busy_a, txn_a}), 72'(17'h0));

        // Clean single-transaction loopback run with cycle-exact command timing
        wq.delete();
        kick(0);
        check("r2_act_row", 72'(A_a), 72'(17'h0));
        check("r2_act_cs",  72'(cs_n_a), 72'(1'b0));
        step_to(28);
        check("rd_A",     72'(A_a),    72'(17'h14000));
        check("rd_cs_n",  72'(cs_n_a), 72'(1'b0));
        step_to(51);
        check("pre_A",    72'(A_a),    72'(17'h08000));
        check("pre_cs_n", 72'(cs_n_a), 72'(1'b0));
        check("pre_txn",  72'(txn_a),  72'(16'd0));
        step_to(52);
        check("post_pre_txn", 72'(txn_a), 72'(16'd1));
        step_to(65);
        check("trp_last_busy", 72'({done_a, busy_a}), 72'(2'b01));
        step_to(66);
        check("done_pulse", 72'({done_a, busy_a}), 72'(2'b10));
        check("lb_err",     72'(err_a), 72'(16'd0));
        check("lb_txn",     72'(txn_a), 72'(16'd1));
        step_to(67);
        check("after_done", 72'({done_a, busy_a}), 72'(2'b00));

        // Bit 0 corrupted on two beats
        wq.delete();
        flip_mask = 72'h1;
        flip_left = 2;
        kick(0);
        wait_done(0, 100);
        check("flip2_err", 72'(err_a), 72'(16'd2));
        step();

        // Only the top ECC bit corrupted on every beat
        wq.delete();
        flip_mask = 72'h80_0000_0000_0000_0000;
        flip_left = 8;
        kick(0);
        wait_done(0, 100);
        check("ecc_err", 72'(err_a), 72'(16'd0));
        check("ecc_txn", 72'(txn_a), 72'(16'd1));
        step();

        // Saturation: preload 16'hFFFE, then eight mismatching beats
        lb_zero = 1'b1;
        kick(0);
        step_to(5);
        force u_a.err_q = 16'hFFFE;
        step();
        release u_a.err_q;
        check("sat_preload", 72'(err_a), 72'(16'hFFFE));
        wait_done(0, 100);
        check("sat_err", 72'(err_a), 72'(16'hFFFF));
        lb_zero = 1'b0;

        // Instance B: column/bank stepping with start pulses ignored while busy
        kick(1);
        step_to(10);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        step_to(16);
        check("b_wr0_A",   72'(A_b),  {55'h0, 3'b100, 14'(exp_col[0])});
        check("b_wr0_ba",  72'(ba_b), 72'(exp_ba[0]));
        check("b_wr0_cmd", 72'({cs_n_b, act_n_b}), 72'(2'b01));
        step_to(40);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("b_busy_41", 72'(busy_b), 72'(1'b1));
        for (int unsigned i = 1; i < 5; i++) begin
            if (i == 2) begin
                step_to(117);
                check("b_ba_hold", 72'(ba_b), 72'(2'd0));
            end
            step_to(16 + 65 * int'(i));
            check("b_wr_A",   72'(A_b),   {55'h0, 3'b100, 14'(exp_col[i])});
            check("b_wr_ba",  72'(ba_b),  72'(exp_ba[i]));
            check("b_wr_bg",  72'(bg_b),  72'(2'd0));
            check("b_wr_txn", 72'(txn_b), 72'(i));
        end
        wait_done(1, 400);
        check("b_done_cyc", 72'(cyc), 72'(326));
        check("b_txn",      72'(txn_b), 72'(16'd5));
        check("b_err",      72'(err_b), 72'(16'd40));
        step();
        kick(1);
        check("b_re_cnts", 72'({err_b, txn_b}), 72'(32'h0));
        check("b_re_row",  72'(A_b),  72'(17'h0));
        step_to(16);
        check("b_re_wr_A",  72'(A_b),  72'(17'h10000));
        check("b_re_wr_ba", 72'(ba_b), 72'(2'd0));
        wait_done(1, 400);
        step();

        // Instance C: rank alternation then row increment
        kick(2);
        for (int unsigned i = 0; i < 5; i++) begin
            step_to(1 + 65 * int'(i));
            check("c_act_cs",  72'(cs_n_c),  72'(exp_cs[i]));
            check("c_act_row", 72'(A_c),     72'(exp_row[i]));
            check("c_act_n",   72'(act_n_c), 72'(1'b0));
        end
        wait_done(2, 400);
        check("c_txn", 72'(txn_c), 72'(16'd5));
        step();

        // Instance D: sixteen transactions of zero read data
        kick(3);
        wait_done(3, 1200);
        check("d_err", 72'(err_d), 72'(16'd128));
        check("d_txn", 72'(txn_d), 72'(16'd16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
